mem_loader: RTL and testbench

Byte-stream program loader for the RISC-V CPU test top. The loader receives a framed byte stream, typically from a UART receiver. It assembles little-endian 32-bit words and drives the top's external memory-write port (Ext_MemWrite, Ext_WriteData, Ext_DataAdr) while it holds the CPU in reset. When the last word is written, it releases the CPU reset so execution starts from the freshly loaded memory.

---
 rtl/mem_loader.sv | 73 +++++++
 tb/tb_mem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: framed byte-stream loader that writes little-endian words to memory, then releases cpu_reset
module mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        done
);
    typedef enum logic [2:0] {ADDR, LEN, DATA, WRITE, DONE} loaderState;
    loaderState state, stateNext;
    logic        armed;
    logic        xfer;
    logic        lastByte;
    logic [1:0]  byteIdx;
    logic [31:0] addr;
    logic [31:0] word;
    logic [15:0] remaining;
    always_comb begin
        stateNext    = state;
        rx_ready     = armed && !reset && (state == ADDR || state == LEN || state == DATA);
        Ext_MemWrite = state == WRITE;
        xfer         = rx_valid && rx_ready;
        lastByte     = byteIdx == ((state == LEN) ? 2'd1 : 2'd3);
        case (state)
            ADDR:    stateNext = (xfer && lastByte) ? LEN : ADDR;
            LEN:     stateNext = (xfer && lastByte) ? (({rx_data, remaining[15:8]} == 16'd0) ? DONE : DATA) : LEN;
            DATA:    stateNext = (xfer && lastByte) ? WRITE : DATA;
            WRITE:   stateNext = (remaining == 16'd1) ? DONE : DATA;
            DONE:    stateNext = DONE;
            default: stateNext = ADDR;
        endcase
    end
    // cpu_reset/done lag entry into DONE by one edge so they are pure registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ADDR;
            armed         <= 1'b0;
            byteIdx       <= 2'd0;
            addr          <= 32'd0;
            word          <= 32'd0;
            remaining     <= 16'd0;
            Ext_WriteData <= 32'd0;
            Ext_DataAdr   <= 32'd0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
        end else begin
            state     <= stateNext;
            armed     <= 1'b1;
            byteIdx   <= (stateNext != state) ? 2'd0 : byteIdx + 2'(xfer);
            cpu_reset <= state != DONE;
            done      <= state == DONE;
            if (xfer && state == ADDR)
                addr <= {rx_data, addr[31:8]};
            if (state == WRITE)
                addr <= addr + 32'd4;
            if (xfer && state == LEN)
                remaining <= {rx_data, remaining[15:8]};
            if (state == WRITE)
                remaining <= remaining - 16'd1;
            if (xfer && state == DATA)
                word <= {rx_data, word[31:8]};
            if (xfer && state == DATA && lastByte) begin
                Ext_WriteData <= {rx_data, word[31:8]};
                Ext_DataAdr   <= {addr[31:2], 2'b00};
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed scenarios for the byte-stream memory loader
module tb_mem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        cpu_reset;
    logic        done;
    int checks = 0;
    int failures = 0;
    logic [7:0]  txq[$];
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];

    mem_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
        .cpu_reset(cpu_reset), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Ext_MemWrite === 1'b1) begin
            wrAddr.push_back(Ext_DataAdr);
            wrData.push_back(Ext_WriteData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wrAddr.delete();
        wrData.delete();
    endtask

    task automatic send_all(input int maxGap);
        while (txq.size() > 0) begin
            int n;
            rx_valid = 1'b0;
            repeat ($urandom_range(maxGap, 0)) @(negedge clk);
            rx_data = txq.pop_front();
            rx_valid = 1'b1;
            for (n = 0; n < 50 && rx_ready !== 1'b1; n++) @(negedge clk);
            if (rx_ready !== 1'b1) begin
                checks++; failures++;
                $display("FAIL send_timeout rx_ready=%b required=1", rx_ready);
                rx_valid = 1'b0;
                txq.delete();
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 20 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL wait_done done=%b required=1", done); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, Ext_MemWrite, cpu_reset, done} !== 4'b0010 || Ext_WriteData !== 32'd0 || Ext_DataAdr !== 32'd0) begin
            failures++;
            $display("FAIL reset_values rdy/we/cpurst/done=%b%b%b%b wd=%h adr=%h required 0010 0 0",
                     rx_ready, Ext_MemWrite, cpu_reset, done, Ext_WriteData, Ext_DataAdr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            failures++; $display("FAIL reset_release_cycle rx_ready=%b cpu_reset=%b required 0 1", rx_ready, cpu_reset);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL ready_rise rx_ready=%b cpu_reset=%b done=%b required 1 1 0", rx_ready, cpu_reset, done);
        end
    endtask

    task automatic test_basic();
        do_reset();
        txq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_all(0);
        checks++;
        if (Ext_MemWrite !== 1'b1 || rx_ready !== 1'b0 || Ext_WriteData !== 32'h00200593 || Ext_DataAdr !== 32'h4) begin
            failures++;
            $display("FAIL basic_write_cycle we=%b rdy=%b wd=%h adr=%h required 1 0 00200593 00000004",
                     Ext_MemWrite, rx_ready, Ext_WriteData, Ext_DataAdr);
        end
        @(negedge clk);
        checks++;
        if (Ext_MemWrite !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_after_write we=%b cpu_reset=%b done=%b required 0 1 0", Ext_MemWrite, cpu_reset, done);
        end
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || Ext_WriteData !== 32'h00200593) begin
            failures++; $display("FAIL basic_release cpu_reset=%b done=%b wd=%h required 0 1 00200593", cpu_reset, done, Ext_WriteData);
        end
        checks++;
        if (wrAddr.size() != 2) begin
            failures++; $display("FAIL basic_count writes=%0d required 2", wrAddr.size());
        end else if (wrAddr[0] !== 32'h0 || wrData[0] !== 32'h00100513 || wrAddr[1] !== 32'h4 || wrData[1] !== 32'h00200593) begin
            failures++;
            $display("FAIL basic_writes %h@%h %h@%h required 00100513@00000000 00200593@00000004",
                     wrData[0], wrAddr[0], wrData[1], wrAddr[1]);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        txq = '{8'h07, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_all(3);
        checks++;
        if (Ext_MemWrite !== 1'b1 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL gaps_write_cycle we=%b rx_ready=%b required 1 0", Ext_MemWrite, rx_ready);
        end
        wait_done();
        repeat (2) @(negedge clk);
        checks++;
        if (wrAddr.size() != 1) begin
            failures++; $display("FAIL gaps_count writes=%0d required 1", wrAddr.size());
        end else if (wrAddr[0] !== 32'h104 || wrData[0] !== 32'hDDCCBBAA) begin
            failures++; $display("FAIL gaps_write %h@%h required ddccbbaa@00000104", wrData[0], wrAddr[0]);
        end
    endtask

    task automatic test_zero();
        do_reset();
        txq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(0);
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL zero_accept_cycle cpu_reset=%b done=%b rx_ready=%b required 1 0 0", cpu_reset, done, rx_ready);
        end
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL zero_release cpu_reset=%b done=%b required 0 1", cpu_reset, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wrAddr.size() != 0) begin failures++; $display("FAIL zero_nowrite writes=%0d required 0", wrAddr.size()); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        txq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        send_all(0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_state cpu_reset=%b rx_ready=%b required 1 0", cpu_reset, rx_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        txq = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_all(1);
        wait_done();
        repeat (2) @(negedge clk);
        checks++;
        if (wrAddr.size() != 1) begin
            failures++; $display("FAIL midreset_count writes=%0d required 1", wrAddr.size());
        end else if (wrAddr[0] !== 32'h20 || wrData[0] !== 32'h12345678) begin
            failures++; $display("FAIL midreset_write %h@%h required 12345678@00000020", wrData[0], wrAddr[0]);
        end
        do_reset();
        txq = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_all(0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (Ext_MemWrite !== 1'b0 || cpu_reset !== 1'b1 || Ext_DataAdr !== 32'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_write we=%b cpu_reset=%b adr=%h done=%b required 0 1 00000000 0",
                     Ext_MemWrite, cpu_reset, Ext_DataAdr, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        txq = '{8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_all(2);
        wait_done();
        checks++;
        if (wrAddr.size() != 2) begin
            failures++; $display("FAIL wrap_count writes=%0d required 2", wrAddr.size());
        end else if (wrAddr[0] !== 32'hFFFFFFFC || wrData[0] !== 32'h1 || wrAddr[1] !== 32'h0 || wrData[1] !== 32'h2) begin
            failures++;
            $display("FAIL wrap_writes %h@%h %h@%h required 00000001@fffffffc 00000002@00000000",
                     wrData[0], wrAddr[0], wrData[1], wrAddr[1]);
        end
    endtask

    task automatic test_post_done();
        rx_data = 8'h13;
        rx_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (rx_ready !== 1'b0 || cpu_reset !== 1'b0 || done !== 1'b1 || Ext_MemWrite !== 1'b0) begin
                failures++;
                $display("FAIL post_done rdy=%b cpu_reset=%b done=%b we=%b required 0 0 1 0",
                         rx_ready, cpu_reset, done, Ext_MemWrite);
            end
        end
        checks++;
        if (wrAddr.size() != 2) begin failures++; $display("FAIL post_done_writes writes=%0d required 2", wrAddr.size()); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL post_done_reset cpu_reset=%b done=%b rx_ready=%b required 1 0 0", cpu_reset, done, rx_ready);
        end
        reset = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_zero();
        test_mid_reset();
        test_wrap();
        test_post_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
